load_store_unit: RTL and testbench

//   Multi-cycle load/store unit between the core's MEM stage and a word-wide memory bus with variable wait states.

---
 rtl/load_store_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit between the core's MEM stage and a word-wide
// req/ack memory bus with variable wait states. A request is captured in IDLE,
// held on the bus in BUSY until bus_ack (or the watchdog fires), and retired in
// DONE, where loads present their aligned and extended data for one cycle.
// While an access is outstanding, stall tells the core to hold its PC and
// request inputs.
//
// Optional feature macro: LSU_STORE_BUF_EN
//   defined   : one-entry posted store buffer. An aligned store accepted in IDLE
//               does not stall. It drains on the bus in the background, and any
//               request that arrives during the drain stalls until the drain
//               retires. Loads never forward from the buffer.
//   undefined : stores stall through IDLE/BUSY/DONE exactly like loads.
//
// Parameters
//   DATA_WIDTH  datapath width (only 32 is supported)
//   TIMEOUT     bus-ack watchdog in BUSY cycles; 0 disables the watchdog
//
// Ports
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   req_valid      MEM-stage memory operation present
//   req_write      1 = store, 0 = load
//   maskmode       00 byte, 01 half, 10/11 word
//   sext           1 = sign-extend loads, 0 = zero-extend
//   address        byte address
//   write_data     store data, right-aligned
//   stall          core must hold PC and request inputs
//   load_data      extended load result (0 unless load_valid)
//   load_valid     one-cycle pulse when a load retires
//   misaligned     request violates natural alignment (combinational)
//   bus_err        one-cycle pulse when an access retires by watchdog timeout
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus request, held until bus_ack
//   bus_ack/bus_rdata                          completion strobe and read word
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            maskmode,
  input  logic                  sext,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured request
  logic [29:0]           r_addr_hi;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [1:0]            r_mask;
  logic                  r_sext;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_bus_err;

  logic                  w_is_half;
  logic                  w_is_word;
  logic                  w_misaligned_raw;
  logic                  w_accept;
  logic                  w_post;     // accepted request goes into the store buffer
  logic                  w_drain;    // current BUSY access is a posted store
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load_ext;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_is_half        = (maskmode == 2'b01);
  assign w_is_word        = maskmode[1];
  assign w_misaligned_raw = (w_is_half & address[0]) | (w_is_word & (|address[1:0]));
  assign misaligned       = req_valid & w_misaligned_raw;
  assign w_accept         = (r_state == ST_IDLE) & req_valid & ~w_misaligned_raw;

  always_comb begin
    w_be = 4'b1111;
    case (maskmode)
      2'b00:   w_be = 4'b0001 << address[1:0];
      2'b01:   w_be = 4'b0011 << address[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select
  // the bytes that land in memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata[8*gi +: 8] = (maskmode == 2'b00) ? write_data[7:0] :
                                  (maskmode == 2'b01) ? write_data[8*(gi%2) +: 8] :
                                                        write_data[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------------------
  assign w_shifted = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_mask)
      2'b00:   w_load_ext = {{(DATA_WIDTH-8){r_sext & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_ext = {{(DATA_WIDTH-16){r_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional posted store buffer
  // ---------------------------------------------------------------------------
`ifdef LSU_STORE_BUF_EN
  logic r_posted;

  assign w_post  = req_write;
  assign w_drain = r_posted;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_posted <= 1'b0;
    end else if (w_accept) begin
      r_posted <= req_write;
    end
  end
`else
  assign w_post  = 1'b0;
  assign w_drain = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus-ack watchdog: counts BUSY cycles. A coincident ack wins over timeout.
  // ---------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [WDW-1:0] r_wdog;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_wdog <= '0;
        end else if (r_state == ST_BUSY) begin
          r_wdog <= r_wdog + WDW'(1);
        end else begin
          r_wdog <= '0;
        end
      end

      assign w_timeout = (r_state == ST_BUSY) && !bus_ack && (r_wdog == WDW'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next state and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_BUSY;
          stall        = ~w_post;
        end
      end
      ST_BUSY: begin
        // A posted store only holds up the core if something new is waiting.
        stall = w_drain ? req_valid : 1'b1;
        if (bus_ack || w_timeout) begin
          // A drained store has no retire cycle; the waiting request is
          // accepted in the following IDLE cycle.
          w_state_next = w_drain ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        // The core still shows the retired request this cycle; never re-accept it.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_addr_hi   <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_mask      <= '0;
      r_sext      <= 1'b0;
      r_off       <= '0;
      r_load_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_addr_hi <= address[31:2];
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_we      <= req_write;
        r_mask    <= maskmode;
        r_sext    <= sext;
        r_off     <= address[1:0];
      end
      if ((r_state == ST_BUSY) && bus_ack) begin
        r_load_data <= w_load_ext;
      end else if (w_timeout) begin
        r_load_data <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the bus idles at zero outside BUSY
  // ---------------------------------------------------------------------------
  assign bus_req    = (r_state == ST_BUSY);
  assign bus_we     = bus_req & r_we;
  assign bus_addr   = bus_req ? {r_addr_hi, 2'b00} : '0;
  assign bus_be     = bus_req ? r_be : '0;
  assign bus_wdata  = bus_req ? r_wdata : '0;
  assign load_valid = (r_state == ST_DONE) & ~r_we;
  assign load_data  = load_valid ? r_load_data : '0;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int TO    = 8;
  localparam int NOACK = 99;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  maskmode;
  logic        sext;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_ack   = 1'b0;
  logic        stray_ack  = 1'b0;

  assign bus_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_write(req_write),
    .maskmode(maskmode), .sext(sext), .address(address), .write_data(write_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    q_bus[$];
  logic [31:0] q_load[$];
  int          q_delay[$];
  int          exp_err = 0;
  int          got_err = 0;
  bit          rst_test = 1'b0;

  logic [7:0]  model_mem[256];   // reference byte memory (architectural view)
  logic [31:0] dev_mem[64];      // bus-side memory device

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  function automatic int nbytes(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] m, input bit sx);
    int n = nbytes(m);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(model_mem[32'(a[7:0]) + k]) << (8 * k));
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Issue one request, hold it until stall drops, return stall cycles.
  task automatic issue(input bit wr, input logic [1:0] mm, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input int d,
                       output int stall_cnt);
    int n = nbytes(mm);
    bit mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    bit done = 1'b0;
    int exp_stall;
    bus_exp_t e;
    if (!mis) begin
      e.we    = wr;
      e.addr  = {a[31:2], 2'b00};
      e.be    = 4'((32'h1 << n) - 1) << a[1:0];
      e.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
      q_delay.push_back(d);
      q_bus.push_back(e);
      if (!wr) q_load.push_back((d == NOACK) ? 32'h0 : model_load(a, mm, sx));
      else if (d != NOACK) for (int k = 0; k < n; k++) model_mem[32'(a[7:0]) + k] = wd[8*k +: 8];
      if (d == NOACK) exp_err++;
    end
    exp_stall = mis ? 0 : (d == NOACK) ? TO + 1 : d + 2;
    req_valid = 1'b1; req_write = wr; maskmode = mm; sext = sx; address = a; write_data = wd;
    stall_cnt = 0;
    @(negedge clk);
    chk("misaligned", {31'h0, misaligned}, {31'h0, mis});
    if (mis) chk("misaligned_load_data", load_data, 32'h0);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (!stall) begin done = 1'b1; break; end
      stall_cnt++;
    end
    if (!done) chk("stall_bound", 32'h0, 32'h1);
`ifndef LSU_STORE_BUF_EN
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("txn we=%0d mask=%0d sext=%0d addr=%08h wd=%08h delay=%0d mis=%0d stall=%0d",
             wr, mm, sx, a, wd, d, mis, stall_cnt);
  endtask

  // Bus-side memory device with per-access ack delay from q_delay.
  initial begin
    bit active = 1'b0;
    int d = 0;
    int cnt = 0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (!rstn) begin
        active = 1'b0;
      end else if (bus_req) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          d = (q_delay.size() > 0) ? q_delay.pop_front() : NOACK;
        end
        if (d != NOACK && cnt == d) begin
          resp_ack = 1'b1;
          if (bus_we) begin
            for (int l = 0; l < 4; l++)
              if (bus_be[l]) dev_mem[bus_addr[7:2]][8*l +: 8] = bus_wdata[8*l +: 8];
          end else begin
            bus_rdata = dev_mem[bus_addr[7:2]];
          end
        end
        cnt++;
      end else if (active) begin
        active = 1'b0;
        if (d == NOACK && !rst_test) chk("timeout_req_len", 32'(cnt), 32'(TO));
      end
    end
  end

  // Scoreboard monitor
  initial begin
    bit prev_req = 1'b0;
    bus_exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && !rst_test) begin
        if (bus_req) begin
          if (q_bus.size() == 0) begin
            chk("unexpected_bus_req", {31'h0, bus_req}, 32'h0);
          end else begin
            e = q_bus[0];
            chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
          end
        end
        if (prev_req && !bus_req && q_bus.size() > 0) void'(q_bus.pop_front());
        if (load_valid) begin
          if (q_load.size() == 0) chk("unexpected_load_valid", {31'h0, load_valid}, 32'h0);
          else chk("load_data", load_data, q_load.pop_front());
        end
        if (bus_err) got_err++;
      end
      prev_req = bus_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int sc;
    int sc2;
    logic [31:0] w;
    logic [31:0] a;
    logic [1:0]  mm;
    int d;
    bit seen;

    for (int i = 0; i < 64; i++) begin
      w = (i == 4) ? 32'hDEADBEEF : $urandom;
      dev_mem[i] = w;
      for (int k = 0; k < 4; k++) model_mem[4*i + k] = w[8*k +: 8];
    end

    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; maskmode = 2'b00;
    sext = 1'b0; address = 32'h0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, sc);              // LW, ack in 3rd BUSY cycle
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80112233, 0, sc);       // SW
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, sc);              // LB sext -> FFFFFF80
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, sc);              // LBU -> 00000080
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 1, sc);       // SH -> be 1100, ABCDABCD
    issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, sc);              // misaligned LW
    issue(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 0, sc);              // misaligned LH
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, sc);              // LH sext of ABCD
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, NOACK, sc);          // timeout load
`ifndef LSU_STORE_BUF_EN
    // A stray ack while idle must be ignored.
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(posedge clk); #1;
`else
    repeat (3) @(posedge clk);
    #1;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 2, sc);      // posted SW
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 2, sc2);             // LW waits for drain
    chk("posted_store_stall", 32'(sc), 32'h0);
    chk("load_after_drain_stall", 32'(sc2), 32'd7);
`endif

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      mm = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (mm == 2'b01) a[0] = 1'b0;
        else if (mm[1]) a[1:0] = 2'b00;
      end
      d = ($urandom_range(0, 11) == 0) ? NOACK : int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), mm, 1'($urandom_range(0, 1)), a, $urandom, d, sc);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (20) @(posedge clk);
    #1;
    chk("pending_loads", 32'(q_load.size()), 32'h0);
    chk("pending_bus", 32'(q_bus.size()), 32'h0);
    chk("bus_err_count", 32'(got_err), 32'(exp_err));

    // Asynchronous reset in the middle of a BUSY access
    rst_test = 1'b1;
    q_delay.push_back(NOACK);
    req_valid = 1'b1; req_write = 1'b0; maskmode = 2'b10; sext = 1'b0; address = 32'h44;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_req) begin seen = 1'b1; break; end
    end
    chk("rst_test_bus_req_seen", {31'h0, seen}, 32'h1);
    #2;
    rstn = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("async_rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("async_rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_load_valid", {31'h0, load_valid}, 32'h0);
      chk("post_rst_bus_req", {31'h0, bus_req}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
